// File: rtl/status_cond_if.sv
// status_cond_if: pipeline/ALU flag bus between the ID/EXE control and status_cond_unit.
interface status_cond_if #(parameter int CNT_W = 16);
    logic [3:0]       SR_in;
    logic             S_ID;
    logic             ID_advance;
    logic             flush;
    logic [3:0]       cond;
    logic [3:0]       SR;
    logic             C;
    logic             cond_pass;
    logic             flag_hazard;
    logic [CNT_W-1:0] stall_count;
    modport master (output SR_in, S_ID, ID_advance, flush, cond,
                    input  SR, C, cond_pass, flag_hazard, stall_count);
    modport slave  (input  SR_in, S_ID, ID_advance, flush, cond,
                    output SR, C, cond_pass, flag_hazard, stall_count);
endinterface

// File: rtl/status_cond_unit.sv
// status_cond_unit: status register commit, condition evaluation and flag hazard stall counting.
// Optional macro STATUS_COND_FWD_EN forwards in-flight ALU flags instead of stalling.
module status_cond_unit #(parameter int CNT_W = 16) (
    input  logic         clk,
    input  logic         rst_n,
    status_cond_if.slave bus
);
    logic             pend;
    logic [3:0]       sr;
    logic [3:0]       f;
    logic [CNT_W-1:0] cnt;
    logic             hazard;
    logic             n, z, c, v;
    logic [15:0]      pass_vec;
`ifdef STATUS_COND_FWD_EN
    assign f      = pend ? bus.SR_in : sr;
    assign hazard = 1'b0;
`else
    assign f      = sr;
    assign hazard = pend & (bus.cond != 4'b1110);
`endif
    assign {n, z, c, v} = f;
    // one bit per condition code, indexed by cond
    assign pass_vec = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
                       ~v, v, ~n, n, ~c, c, ~z, z};
    assign bus.cond_pass   = pass_vec[bus.cond];
    assign bus.flag_hazard = hazard;
    assign bus.SR          = sr;
    assign bus.C           = sr[1];
    assign bus.stall_count = cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
            sr   <= 4'b0000;
            cnt  <= '0;
        end else begin
            pend <= bus.ID_advance & bus.S_ID & ~bus.flush;
            if (pend) sr <= bus.SR_in;
            if (hazard && !(&cnt)) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_status_cond_unit.sv
// tb_status_cond_unit: table vectors plus a commit scoreboard for status_cond_unit.
module tb_status_cond_unit;
    localparam int CNT_W = 16;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;

    status_cond_if #(.CNT_W(CNT_W)) bus ();
    status_cond_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [3:0]       m_sr;
    logic             m_pend = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic [3:0]       sbq[$];

    typedef struct {
        logic [3:0] sr;
        logic [3:0] cond;
        logic       pass;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_model(input logic [3:0] fl, input logic [3:0] cd);
        logic n, z, c, v;
        {n, z, c, v} = fl;
        case (cd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // one clock: drive, check combinational outputs, take the edge, check registers
    task automatic cyc(input logic adv, input logic s, input logic fl, input logic [3:0] sr_in,
                       input logic [3:0] cd);
        logic       hz;
        logic [3:0] ef;
        bus.ID_advance = adv;
        bus.S_ID       = s;
        bus.flush      = fl;
        bus.SR_in      = sr_in;
        bus.cond       = cd;
        #2;
`ifdef STATUS_COND_FWD_EN
        hz = 1'b0;
        ef = m_pend ? sr_in : m_sr;
`else
        hz = m_pend && (cd != 4'b1110);
        ef = m_sr;
`endif
        if (rst_n) begin
            chk("flag_hazard", bus.flag_hazard, hz);
            if (!hz) chk("cond_pass", bus.cond_pass, cond_model(ef, cd));
            if (m_pend) sbq.push_back(sr_in);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_sr = 4'b0000;
            m_pend = 1'b0;
            m_cnt = '0;
            sbq.delete();
        end else begin
            if (m_pend) m_sr = sbq.pop_front();
            if (hz && m_cnt != '1) m_cnt = m_cnt + 1'b1;
            m_pend = adv && s && !fl;
        end
        chk("SR", bus.SR, m_sr);
        chk("C", bus.C, m_sr[1]);
        chk("stall_count", bus.stall_count, m_cnt);
    endtask

    task automatic set_sr(input logic [3:0] val);
        cyc(1, 1, 0, 4'b0000, 4'b1110);
        cyc(0, 0, 0, val, 4'b1110);
    endtask

    initial begin
        tbl[0]  = '{4'b0100, 4'd0,  1'b1};
        tbl[1]  = '{4'b0100, 4'd1,  1'b0};
        tbl[2]  = '{4'b0010, 4'd2,  1'b1};
        tbl[3]  = '{4'b0010, 4'd3,  1'b0};
        tbl[4]  = '{4'b1000, 4'd4,  1'b1};
        tbl[5]  = '{4'b1000, 4'd5,  1'b0};
        tbl[6]  = '{4'b0001, 4'd6,  1'b1};
        tbl[7]  = '{4'b0001, 4'd7,  1'b0};
        tbl[8]  = '{4'b0010, 4'd8,  1'b1};
        tbl[9]  = '{4'b0110, 4'd8,  1'b0};
        tbl[10] = '{4'b0110, 4'd9,  1'b1};
        tbl[11] = '{4'b1001, 4'd10, 1'b1};
        tbl[12] = '{4'b1000, 4'd11, 1'b1};
        tbl[13] = '{4'b0000, 4'd12, 1'b1};
        tbl[14] = '{4'b0100, 4'd13, 1'b1};
        tbl[15] = '{4'b0000, 4'd14, 1'b1};
        tbl[16] = '{4'b1111, 4'd15, 1'b0};
        m_sr = 4'b0000;

        rst_n = 1'b0;
        cyc(1, 1, 0, 4'b1111, 4'b1110);
        cyc(1, 1, 0, 4'b1111, 4'b1110);
        chk("reset_SR", bus.SR, 4'b0000);
        chk("reset_stall", bus.stall_count, 0);
        chk("reset_hazard", bus.flag_hazard, 1'b0);
        rst_n = 1'b1;
        cyc(1, 1, 0, 4'b0000, 4'b1110);
        cyc(0, 0, 0, 4'b0110, 4'b1110);
        chk("first_commit", bus.SR, 4'b0110);

        set_sr(4'b0010);
        chk("adds_C", bus.C, 1'b1);
        cyc(0, 0, 0, 4'b0000, 4'b0010);
        chk("cs_pass", bus.cond_pass, 1'b1);
        cyc(0, 0, 0, 4'b0000, 4'b0000);
        chk("eq_fail", bus.cond_pass, 1'b0);

        cyc(1, 1, 0, 4'b0000, 4'b0000);
        cyc(0, 0, 0, 4'b0100, 4'b0000);
`ifdef STATUS_COND_FWD_EN
        chk("fwd_stall_zero", bus.stall_count, 0);
`else
        chk("stall_one", bus.stall_count, 1);
`endif
        cyc(0, 0, 0, 4'b0000, 4'b0000);
        chk("eq_after_commit", bus.cond_pass, 1'b1);
        chk("hazard_cleared", bus.flag_hazard, 1'b0);
        cyc(1, 1, 0, 4'b0000, 4'b1110);
        cyc(0, 0, 0, 4'b1000, 4'b1110);

        cyc(1, 1, 0, 4'b0000, 4'b1110);
        cyc(1, 1, 1, 4'b1000, 4'b1110);
        chk("flush_commit", bus.SR, 4'b1000);
        cyc(0, 0, 0, 4'b0001, 4'b1110);
        chk("flush_ignored", bus.SR, 4'b1000);

        cyc(1, 1, 0, 4'b1111, 4'b1110);
        cyc(1, 1, 0, 4'b0011, 4'b0010);
        chk("back_to_back_C", bus.C, 1'b1);
        cyc(0, 0, 0, 4'b0000, 4'b1110);

        for (int i = 0; i < 17; i++) begin
            set_sr(tbl[i].sr);
            cyc(0, 0, 0, 4'b0000, tbl[i].cond);
            chk($sformatf("tbl%0d", i), bus.cond_pass, tbl[i].pass);
        end

        for (int s = 0; s < 16; s++) begin
            set_sr(4'(s));
            for (int k = 0; k < 16; k++) cyc(0, 0, 0, 4'b0000, 4'(k));
        end

        cyc(1, 1, 0, 4'b0000, 4'b1110);
        cyc(0, 0, 0, 4'b0100, 4'b0000);
`ifdef STATUS_COND_FWD_EN
        chk("fwd_stall_still_zero", bus.stall_count, 0);
`else
        // keep a writer in EXE with a dependent condition until the counter pins at all-ones
        for (int i = 0; i < 65540; i++) cyc(1, 1, 0, 4'(i), 4'b0000);
        chk("stall_saturated", bus.stall_count, 16'hFFFF);
        cyc(0, 0, 0, 4'b0000, 4'b0000);
        chk("stall_no_wrap", bus.stall_count, 16'hFFFF);
`endif

        rst_n = 1'b0;
        cyc(1, 1, 0, 4'b1111, 4'b0000);
        chk("reset_mid_commit", bus.SR, 4'b0000);
        chk("reset_clears_stall", bus.stall_count, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 4'b1111, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Consumer side of the ALU flag interface. Captures the 4-bit SR {N,Z,C,V} that the ALU produces into the architectural status register.
- Supplies the carry-in C back to the ALU.
- Evaluates the 4-bit condition field of the instruction in ID against the flags.
- Tracks in-flight flag writers, detects the flag hazard, and counts hazard stall cycles.
- Sits between the ID/EXE pipeline control and the ALU.

Parameters:
- CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- SR_in  input  4  ALU flags {N,Z,C,V}, bit3 = N, bit0 = V. Valid in the cycle the writer is in EXE.
- S_ID  input  1  instruction in ID sets flags.
- ID_advance  input  1  instruction in ID moves to EXE at this edge.
- flush  input  1  squash the instruction entering EXE.
- cond  input  4  condition field of the instruction in ID.
- SR  output  4  committed status register.
- C  output  1  carry-in to the ALU; equals SR[1].
- cond_pass  output  1  condition of the ID instruction is satisfied.
- flag_hazard  output  1  ID condition depends on uncommitted flags; the controller must hold ID (drive ID_advance = 0).
- stall_count  output  CNT_W  number of cycles with flag_hazard = 1.

Behaviour:
- Reset: when rst_n = 0 at an edge, SR = 4'b0000, the internal pend flag = 0 and stall_count = 0. Reset overrides every other input, including mid-commit.
- pend register (an EXE-stage flag writer is present), next value:
  - ID_advance & S_ID & ~flush -> 1.
  - Otherwise -> 0, because a bubble or squashed instruction enters EXE.
- Commit: if pend = 1 at an edge, SR <= SR_in; otherwise SR holds. Latency from the writer entering EXE to SR updated: 1 cycle (updated at the end of its EXE cycle).
- flush kills only the instruction entering EXE. A writer already in EXE (pend = 1) still commits in the same cycle.
- Effective flags F:
  - Without the optional feature, F = SR.
  - C always equals committed SR[1], never SR_in.
- cond_pass is combinational from cond and F:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C.
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 0 (reserved, never passes).
- flag_hazard = pend & (cond != 4'b1110), combinational. While flag_hazard = 1, cond_pass is invalid and may be ignored.
- Stall counter: increments by 1 at each edge where flag_hazard = 1. It saturates at all-ones and does not wrap.
- Back-to-back flag writers (e.g. ADDS then ADCS): the second writer's C sees the first writer's committed carry, because commit happens before the second writer's EXE cycle.

Optional Feature:
- Macro: STATUS_COND_FWD_EN.
- Defined:
  - F = pend ? SR_in : SR, so conditions are evaluated on forwarded flags.
  - flag_hazard is tied to 0 and stall_count stays 0.
  - C is still the committed SR[1].
- Undefined: behaviour is exactly as in Behaviour above (stall-based).

Test Plan:
- Reset: rst_n = 0 for 2 cycles with SR_in = 4'b1111 and S_ID = ID_advance = 1 -> SR = 0, C = 0, stall_count = 0, flag_hazard = 0. After release, the first edge with ID_advance = S_ID = 1 sets pend, and SR_in = 4'b0110 commits at the next edge.
- Commit and carry: ADDS with SR_in = 4'b0010 commits -> SR = 4'b0010, C = 1. Then cond = 0010 (CS) gives cond_pass = 1; cond = 0000 (EQ) gives 0.
- Hazard, feature off: writer in EXE (pend = 1) with cond = 0000 -> flag_hazard = 1 for exactly 1 cycle, stall_count = 1. The next cycle evaluates EQ on the newly committed SR = 4'b0100 -> cond_pass = 1. Repeating with cond = 1110 (AL) gives flag_hazard = 0.
- Flush: ID_advance = S_ID = flush = 1 while pend = 1 with SR_in = 4'b1000 -> SR = 4'b1000 (current writer commits), pend = 0. Next cycle SR_in = 4'b0001 is ignored and SR stays 4'b1000.
- All 16 conditions: sweep cond 0..15 for each of the 16 SR values -> cond_pass matches the table above, and 1111 always gives 0.
- With STATUS_COND_FWD_EN defined: pend = 1, SR = 0, SR_in = 4'b0100, cond = 0000 -> cond_pass = 1 and flag_hazard = 0 in the same cycle; stall_count stays 0.
